// File: rtl/operand_fetch_if.sv
// Decode-side and execute-side valid/ready handshakes of the operand-fetch stage.
// The stage connects through the slave modport; the surrounding pipeline connects through master.
interface operand_fetch_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int WIDTH      = 32,
    parameter int OP_WIDTH   = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [OP_WIDTH-1:0]   in_op;
    logic [ADDR_WIDTH-1:0] in_rd;
    logic [ADDR_WIDTH-1:0] in_rs1;
    logic [ADDR_WIDTH-1:0] in_rs2;
    logic                  in_use1;
    logic                  in_use2;

    logic                  out_valid;
    logic                  out_ready;
    logic [OP_WIDTH-1:0]   out_op;
    logic [ADDR_WIDTH-1:0] out_rd;
    logic [WIDTH-1:0]      out_a;
    logic [WIDTH-1:0]      out_b;

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_use1, in_use2, out_ready,
        output in_ready, out_valid, out_op, out_rd, out_a, out_b
    );

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_use1, in_use2, out_ready,
        input  in_ready, out_valid, out_op, out_rd, out_a, out_b
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads rs1/rs2 from a registered-read bank and keeps operands coherent with write-back.
// Build option OPF_FORWARD_EN: forward write-back data seen in READ/CAPT; otherwise re-issue the reads.
module operand_fetch #(
    parameter int ADDR_WIDTH = 4,
    parameter int WIDTH      = 32,
    parameter int OP_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    operand_fetch_if.slave        bus,
    output logic                  read_port_1,
    output logic                  read_port_2,
    output logic [ADDR_WIDTH-1:0] addr_port_1,
    output logic [ADDR_WIDTH-1:0] addr_port_2,
    input  logic [WIDTH-1:0]      dout_port_1,
    input  logic [WIDTH-1:0]      dout_port_2,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [WIDTH-1:0]      wb_data
);
    typedef enum logic [1:0] {IDLE, READ, CAPT, VALID} state_e;

    state_e                state_q, state_d;
    logic [OP_WIDTH-1:0]   op_q, op_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [ADDR_WIDTH-1:0] rs1_q, rs1_d;
    logic [ADDR_WIDTH-1:0] rs2_q, rs2_d;
    logic                  use1_q, use1_d;
    logic                  use2_q, use2_d;
    logic                  rp1_q, rp1_d;
    logic                  rp2_q, rp2_d;
    logic                  valid_q, valid_d;
    logic [WIDTH-1:0]      a_q, a_d;
    logic [WIDTH-1:0]      b_q, b_d;

    logic                  accept;
    logic                  hit1, hit2;
    logic [WIDTH-1:0]      cap1, cap2;

    assign bus.in_ready  = (state_q == IDLE) | ((state_q == VALID) & bus.out_ready);
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.out_valid = valid_q;
    assign bus.out_op    = op_q;
    assign bus.out_rd    = rd_q;
    assign bus.out_a     = a_q;
    assign bus.out_b     = b_q;
    assign read_port_1   = rp1_q;
    assign read_port_2   = rp2_q;
    assign addr_port_1   = rs1_q;
    assign addr_port_2   = rs2_q;

    // A write-back hit only matters for an operand that is actually used.
    assign hit1 = wb_en & (wb_addr == rs1_q) & use1_q;
    assign hit2 = wb_en & (wb_addr == rs2_q) & use2_q;

`ifdef OPF_FORWARD_EN
    logic             fh1_q, fh1_d;
    logic             fh2_q, fh2_d;
    logic [WIDTH-1:0] fd1_q, fd1_d;
    logic [WIDTH-1:0] fd2_q, fd2_d;

    assign cap1 = !use1_q ? '0 : hit1 ? wb_data : fh1_q ? fd1_q : dout_port_1;
    assign cap2 = !use2_q ? '0 : hit2 ? wb_data : fh2_q ? fd2_q : dout_port_2;
`else
    logic reread_q, reread_d;

    assign cap1 = use1_q ? dout_port_1 : '0;
    assign cap2 = use2_q ? dout_port_2 : '0;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        use1_d  = use1_q;
        use2_d  = use2_q;
        rp1_d   = rp1_q;
        rp2_d   = rp2_q;
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
`ifdef OPF_FORWARD_EN
        fh1_d   = fh1_q;
        fh2_d   = fh2_q;
        fd1_d   = fd1_q;
        fd2_d   = fd2_q;
`else
        reread_d = reread_q;
`endif

        case (state_q)
            READ: begin
                rp1_d   = 1'b0;
                rp2_d   = 1'b0;
                state_d = CAPT;
`ifdef OPF_FORWARD_EN
                if (hit1) begin
                    fh1_d = 1'b1;
                    fd1_d = wb_data;
                end
                if (hit2) begin
                    fh2_d = 1'b1;
                    fd2_d = wb_data;
                end
`else
                // The bank returns pre-write data for this read; remember to read again.
                if (hit1 || hit2) reread_d = 1'b1;
`endif
            end
            CAPT: begin
`ifdef OPF_FORWARD_EN
                a_d     = cap1;
                b_d     = cap2;
                valid_d = 1'b1;
                state_d = VALID;
`else
                if (reread_q || hit1 || hit2) begin
                    rp1_d    = use1_q;
                    rp2_d    = use2_q;
                    reread_d = 1'b0;
                    state_d  = READ;
                end else begin
                    a_d     = cap1;
                    b_d     = cap2;
                    valid_d = 1'b1;
                    state_d = VALID;
                end
`endif
            end
            VALID: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (hit1) a_d = wb_data;
                    if (hit2) b_d = wb_data;
                end
            end
            default: ;
        endcase

        // Accept is possible from IDLE or on the VALID handoff edge; it overrides the next state.
        if (accept) begin
            op_d    = bus.in_op;
            rd_d    = bus.in_rd;
            rs1_d   = bus.in_rs1;
            rs2_d   = bus.in_rs2;
            use1_d  = bus.in_use1;
            use2_d  = bus.in_use2;
            rp1_d   = bus.in_use1;
            rp2_d   = bus.in_use2;
            state_d = READ;
`ifdef OPF_FORWARD_EN
            fh1_d   = 1'b0;
            fh2_d   = 1'b0;
`else
            reread_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            use1_q  <= 1'b0;
            use2_q  <= 1'b0;
            rp1_q   <= 1'b0;
            rp2_q   <= 1'b0;
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
`ifdef OPF_FORWARD_EN
            fh1_q   <= 1'b0;
            fh2_q   <= 1'b0;
            fd1_q   <= '0;
            fd2_q   <= '0;
`else
            reread_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            use1_q  <= use1_d;
            use2_q  <= use2_d;
            rp1_q   <= rp1_d;
            rp2_q   <= rp2_d;
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
`ifdef OPF_FORWARD_EN
            fh1_q   <= fh1_d;
            fh2_q   <= fh2_d;
            fd1_q   <= fd1_d;
            fd2_q   <= fd2_d;
`else
            reread_q <= reread_d;
`endif
        end
    end
endmodule
